// File: rtl/serial_subtractor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_subtractor : bit-serial a-b (LSB first) with borrow and overflow
// rev 1.0
// ---------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
);

   localparam int C_CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sr;
   logic               r_bin;
   logic               r_amsb;
   logic               r_bmsb;
   logic [C_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_diff;
   logic               r_borrow;
   logic               r_ovf;

   logic w_accept;
   logic w_last;
   logic w_d;
   logic w_bout;

   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = (r_cnt == C_CNT_W'(WIDTH - 1));
   assign w_d      = r_a[0] ^ r_b[0] ^ r_bin;
   assign w_bout   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bin);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DONE;
         S_DONE:  w_next = start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_sr     <= '0;
         r_bin    <= 1'b0;
         r_amsb   <= 1'b0;
         r_bmsb   <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_amsb <= a[WIDTH-1];
            r_bmsb <= b[WIDTH-1];
            r_bin  <= 1'b0;
            r_cnt  <= '0;
         end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_sr  <= {w_d, r_sr[WIDTH-1:1]};
            r_bin <= w_bout;
            r_cnt <= r_cnt + C_CNT_W'(1);
            // Results are captured on the edge entering DONE so they are valid in the done cycle
            if (w_last) begin
               r_diff   <= {w_d, r_sr[WIDTH-1:1]};
               r_borrow <= w_bout;
               r_ovf    <= (r_amsb != r_bmsb) && (w_d != r_amsb);
            end
         end
      end
   end

   assign busy     = (r_state == S_RUN);
   assign done     = (r_state == S_DONE);
   assign diff     = r_diff;
   assign borrow   = r_borrow;
   assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// tb_serial_subtractor : directed and random checks of serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
   logic         overflow;

   int n_cmp = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .diff     (diff),
      .borrow   (borrow),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One isolated operation; operands are scrambled right after acceptance.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [W-1:0] ediff, input logic eborrow, input logic eovf,
                         input string tag);
      logic [W-1:0] prev;
      logic         held_ok;
      int           n;
      prev = diff;
      @(negedge clk);
      a = ta; b = tb_; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~ta; b = ~tb_;
      n = 0;
      held_ok = 1'b1;
      while (busy && n < 40) begin
         if (diff !== prev || done) held_ok = 1'b0;
         n++;
         @(negedge clk);
      end
      check({tag, " busy_cycles"}, n, 8);
      check({tag, " held"}, {31'd0, held_ok}, 1);
      check({tag, " done"}, {31'd0, done}, 1);
      check({tag, " diff"}, {24'd0, diff}, {24'd0, ediff});
      check({tag, " borrow"}, {31'd0, borrow}, {31'd0, eborrow});
      check({tag, " overflow"}, {31'd0, overflow}, {31'd0, eovf});
      @(negedge clk);
      check({tag, " done_pulse"}, {31'd0, done}, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] ref9;
      int         sa, sb, sd, n, m, dones;
      logic [W-1:0] ra, rb;

      reset = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("rst busy", {31'd0, busy}, 0);
      check("rst done", {31'd0, done}, 0);
      check("rst diff", {24'd0, diff}, 0);
      check("rst borrow", {31'd0, borrow}, 0);
      check("rst overflow", {31'd0, overflow}, 0);
      reset = 1'b0;
      @(negedge clk);

      run_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0, "100-37");
      run_op(8'd5,   8'd9,  8'hFC, 1'b1, 1'b0, "5-9");
      run_op(8'h80,  8'h01, 8'h7F, 1'b0, 1'b1, "80-01");
      run_op(8'h7F,  8'hFF, 8'h80, 1'b1, 1'b1, "7F-FF");
      run_op(8'h00,  8'h00, 8'h00, 1'b0, 1'b0, "00-00");

      // Back-to-back with start held high; operands changed mid-run
      @(negedge clk);
      a = 8'd200; b = 8'd50; start = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 3) begin a = 8'd10; b = 8'd20; end
      end while (!done && n < 40);
      check("b2b first_latency", n, 9);
      check("b2b first_diff", {24'd0, diff}, 150);
      check("b2b first_borrow", {31'd0, borrow}, 0);
      m = 0;
      do begin
         @(negedge clk);
         m++;
         if (m < 9) check("b2b diff_hold", {24'd0, diff}, 150);
      end while (!done && m < 40);
      start = 1'b0;
      check("b2b spacing", m, 9);
      check("b2b second_diff", {24'd0, diff}, 8'hF6);
      check("b2b second_borrow", {31'd0, borrow}, 1);
      check("b2b second_overflow", {31'd0, overflow}, 0);
      @(negedge clk);
      check("b2b idle_done", {31'd0, done}, 0);
      check("b2b idle_busy", {31'd0, busy}, 0);

      // Reset during RUN cycle 4 aborts the operation
      @(negedge clk);
      a = 8'd3; b = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort in_run", {31'd0, busy}, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy", {31'd0, busy}, 0);
      check("abort done", {31'd0, done}, 0);
      check("abort diff", {24'd0, diff}, 0);
      check("abort borrow", {31'd0, borrow}, 0);
      check("abort overflow", {31'd0, overflow}, 0);
      dones = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort no_done", dones, 0);
      check("abort diff_after", {24'd0, diff}, 0);

      // Random sweep against an independent arithmetic reference
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         ref9 = {1'b0, ra} - {1'b0, rb};
         sa = $signed(ra);
         sb = $signed(rb);
         sd = sa - sb;
         run_op(ra, rb, ref9[7:0], ref9[8], (sd > 127) || (sd < -128), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
